// File: rtl/rca_seq_add_ctrl.sv
// Nibble-serial adder controller: one shared 4-bit ripple-carry adder, one nibble per clock, LSB first.
// Optional macro RCA_SUB_EN adds a 'sub' input for two's-complement subtraction.

module ripple_carry_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [4:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign S[i]     = A[i] ^ B[i] ^ c[i];
        assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[4];
endmodule

module rca_seq_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef RCA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_width_check
        $error("rca_seq_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q,     a_d;
    logic [WIDTH-1:0]  b_q,     b_d;
    logic [WIDTH-1:0]  sum_q,   sum_d;
    logic              cout_q,  cout_d;

    logic [3:0]        a_nib, b_nib, s_nib;
    logic              c_nib;
    logic              last_nib;

    assign a_nib    = a_q[4*idx_q +: 4];
    assign b_nib    = b_q[4*idx_q +: 4];
    assign last_nib = (idx_q == IDXW'(NIBBLES - 1));

    ripple_carry_adder u_rca (
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry_q),
        .S    (s_nib),
        .Cout (c_nib)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_nib) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and per-nibble result write-back; sum keeps its upper nibbles until overwritten.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = op_a;
                    idx_d = '0;
`ifdef RCA_SUB_EN
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
`else
                    b_d     = op_b;
                    carry_d = cin;
`endif
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = s_nib;
                carry_d             = c_nib;
                if (last_nib) begin
                    idx_d  = '0;
                    cout_d = c_nib;
                end else begin
                    idx_d  = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end
endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Directed self-checking bench for rca_seq_add_ctrl at WIDTH=16.
// Subtraction checks are compiled in only when RCA_SUB_EN is defined.

module tb_rca_seq_add_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] op_a, op_b;
    logic        cin;
`ifdef RCA_SUB_EN
    logic        sub;
`endif
    logic        busy, done, cout;
    logic [15:0] sum;

    int n_cmp = 0;
    int n_err = 0;

    rca_seq_add_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
`ifdef RCA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Pulse start for one edge, then wait (bounded) for done; returns cycles-to-done and busy cycle count.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          output int lat, output int bcnt);
        op_a = a; op_b = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [15:0] es, input logic ec);
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++; $display("FAIL %s_done: got %b want 1", name, done);
        end
        n_cmp++;
        if (sum !== es) begin
            n_err++; $display("FAIL %s_sum: got %h want %h", name, sum, es);
        end
        n_cmp++;
        if (cout !== ec) begin
            n_err++; $display("FAIL %s_cout: got %b want %b", name, cout, ec);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
`ifdef RCA_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, cout, sum} !== 19'd0) begin
            n_err++; $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h want all 0",
                              busy, done, cout, sum);
        end
    endtask

    task automatic test_basic;
        int lat, bcnt;
        run_op(16'h1234, 16'h4321, 1'b0, lat, bcnt);
        n_cmp++;
        if (lat !== 5) begin
            n_err++; $display("FAIL basic_latency: got %0d want 5", lat);
        end
        n_cmp++;
        if (bcnt !== 4) begin
            n_err++; $display("FAIL basic_busy_cycles: got %0d want 4", bcnt);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL basic_busy_at_done: got %b want 0", busy);
        end
        check_result("basic", 16'h5555, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL basic_done_width: got %b want 0", done);
        end
    endtask

    task automatic test_carry;
        int lat, bcnt;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, bcnt);
        check_result("carry_ripple", 16'h0000, 1'b1);
        @(negedge clk);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, lat, bcnt);
        check_result("carry_max", 16'hFFFF, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_hold;
        int lat, bcnt;
        run_op(16'h1234, 16'h4321, 1'b0, lat, bcnt);
        check_result("hold_op", 16'h5555, 1'b0);
        for (int i = 0; i < 10; i++) begin
            op_a = 16'(i * 16'h1357); op_b = ~op_a; cin = i[0];
            @(negedge clk);
            n_cmp++;
            if (sum !== 16'h5555 || cout !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL hold_%0d: got sum=%h cout=%b busy=%b want 5555/0/0",
                                  i, sum, cout, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, gap;
        op_a = 16'h0001; op_b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        op_a = 16'h00FF; op_b = 16'h0001;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_result("b2b_first", 16'h0002, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle_after_done: got busy=%b want 0", busy);
        end
        gap = 1;
        while (!done && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        n_cmp++;
        if (gap !== 6) begin
            n_err++; $display("FAIL b2b_throughput: got %0d want 6", gap);
        end
        check_result("b2b_second", 16'h0100, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, bcnt, seen;
        op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, cout, sum} !== 19'd0) begin
            n_err++; $display("FAIL rst_mid_state: got busy=%b done=%b cout=%b sum=%h want all 0",
                              busy, done, cout, sum);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", seen);
        end
        run_op(16'h1234, 16'h4321, 1'b0, lat, bcnt);
        n_cmp++;
        if (lat !== 5) begin
            n_err++; $display("FAIL rst_mid_recover_latency: got %0d want 5", lat);
        end
        check_result("rst_mid_recover", 16'h5555, 1'b0);
        @(negedge clk);
    endtask

`ifdef RCA_SUB_EN
    task automatic test_sub;
        int lat, bcnt;
        sub = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, lat, bcnt);
        check_result("sub_borrow", 16'hFFFE, 1'b0);
        @(negedge clk);
        run_op(16'h0007, 16'h0005, 1'b0, lat, bcnt);
        check_result("sub_noborrow", 16'h0002, 1'b1);
        @(negedge clk);
        sub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef RCA_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
